lsu_bus_adapter: RTL and testbench

Parametrised load/store unit placed between the pipelined core's memory stage and a variable-latency data bus. It replaces the single-cycle data-memory port (address, write data, write strobe, same-cycle read data) with a valid/ready request channel and a valid-only response channel. It generates byte enables and sign or zero extension for all RV load/store widths. While an access is in flight it drives a stall to the hazard unit, and it flags misaligned and timed-out accesses.

---
 rtl/riscv_lsu_pkg.sv | 35 +++
 rtl/lsu_align.sv | 71 +++++++
 rtl/lsu_bus_adapter.sv | 142 ++++++++++++++
 tb/tb_lsu_bus_adapter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared types and helpers for the load/store bus adapter: FSM state
// encoding, RV funct3 width codes and the access-size decode.
package riscv_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;
  localparam logic [2:0] SD = 3'b011;

  // Doubleword codes collapse to a word access on a 32-bit datapath.
  function automatic logic [3:0] size_bytes(input logic [2:0] f3, input int xlen);
    case (f3[1:0])
      2'b00:   size_bytes = 4'd1;
      2'b01:   size_bytes = 4'd2;
      2'b10:   size_bytes = 4'd4;
      default: size_bytes = (xlen == 64) ? 4'd8 : 4'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication,
// load extraction with sign/zero extension, and misalignment detection.
module lsu_align
  import riscv_lsu_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int OFFW = $clog2(NB)
) (
  input  logic [2:0]      funct3,
  input  logic [OFFW-1:0] offset,
  input  logic [XLEN-1:0] writedata,
  input  logic [XLEN-1:0] rdata,
  output logic [NB-1:0]   be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] loaddata,
  output logic            misalign
);

  logic [3:0]      size;
  logic [NB-1:0]   size_mask;
  logic [XLEN-1:0] keep_mask;
  logic [XLEN-1:0] shifted;
  logic            sign_bit;
  logic            is_unsigned;

  assign size = size_bytes(funct3, XLEN);

  always_comb begin
    size_mask = '0;
    keep_mask = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < int'(size)) begin
        size_mask[i]     = 1'b1;
        keep_mask[i*8+:8] = 8'hFF;
      end
    end
  end

  assign be       = size_mask << offset;
  assign misalign = |(offset & OFFW'(size - 4'd1));

  always_comb begin
    wdata = writedata;
    for (int i = 0; i < NB; i++) begin
      case (size)
        4'd1:    wdata[i*8+:8] = writedata[7:0];
        4'd2:    wdata[i*8+:8] = writedata[(i%2)*8+:8];
        4'd4:    wdata[i*8+:8] = writedata[(i%4)*8+:8];
        default: wdata[i*8+:8] = writedata[i*8+:8];
      endcase
    end
  end

  assign shifted = rdata >> {offset, 3'b000};

  // Bytes above the access size are filled with the sign bit or zero.
  always_comb begin
    case (funct3)
      LBU, LHU, LWU: is_unsigned = 1'b1;
      default:       is_unsigned = 1'b0;
    endcase
    case (size)
      4'd1:    sign_bit = shifted[7];
      4'd2:    sign_bit = shifted[15];
      default: sign_bit = shifted[31];
    endcase
    loaddata = (shifted & keep_mask) | ((sign_bit && !is_unsigned) ? ~keep_mask : '0);
  end

endmodule

// File: rtl/lsu_bus_adapter.sv
// Load/store unit bridging the M stage to a valid/ready request, valid-only
// response bus; stalls the pipeline while an access is outstanding.
module lsu_bus_adapter
  import riscv_lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memreadM,
  input  logic              memwriteM,
  input  logic [2:0]        funct3M,
  input  logic [XLEN-1:0]   aluresultM,
  input  logic [XLEN-1:0]   writedataM,
  output logic [XLEN-1:0]   readdataM,
  output logic              stallM,
  output logic              misalignM,
  output logic              buserrM,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_be,
  input  logic              bus_rsp_valid,
  input  logic [XLEN-1:0]   bus_rdata,
  output logic [1:0]        lsu_state
);

  // Request channel: a request transfers on a cycle with bus_req_valid &
  // bus_req_ready; once valid rises its fields stay constant until then.
  // Response channel: bus_rsp_valid is honoured only while in WAIT.

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] REQ  = ST_REQ;
  localparam logic [1:0] WAIT = ST_WAIT;
  localparam logic [1:0] DONE = ST_DONE;

  logic [1:0]      state;
  logic [1:0]      state_next;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [2:0]      req_f3;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;
  logic [CW-1:0]   cnt;

  logic            access;
  logic            in_idle;
  logic            issue;
  logic            timeout_hit;
  logic [2:0]      sel_f3;
  logic [XLEN-1:0] sel_addr;
  logic [XLEN-1:0] sel_wdata;
  logic [NB-1:0]   al_be;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_load;
  logic            al_mis;

  assign access  = memreadM | memwriteM;
  assign in_idle = (state == IDLE);

  // In IDLE the request is built straight from M; afterwards from the copy.
  assign sel_f3    = in_idle ? funct3M    : req_f3;
  assign sel_addr  = in_idle ? aluresultM : req_addr;
  assign sel_wdata = in_idle ? writedataM : req_wdata;

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3    (sel_f3),
    .offset    (sel_addr[OFFW-1:0]),
    .writedata (sel_wdata),
    .rdata     (bus_rdata),
    .be        (al_be),
    .wdata     (al_wdata),
    .loaddata  (al_load),
    .misalign  (al_mis)
  );

  assign issue       = in_idle & access & ~al_mis;
  assign timeout_hit = TO_EN && (cnt == CNT_LAST);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (issue) state_next = bus_req_ready ? WAIT : REQ;
      REQ:     if (bus_req_ready) state_next = WAIT;
      WAIT:    if (bus_rsp_valid || timeout_hit) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_f3    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      state <= state_next;
      if (issue) begin
        req_we    <= memwriteM;
        req_addr  <= aluresultM;
        req_wdata <= writedataM;
        req_f3    <= funct3M;
      end
      cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
      if (state == WAIT) begin
        if (bus_rsp_valid) begin
          rsp_data <= req_we ? '0 : al_load;
          rsp_err  <= 1'b0;
        end else if (timeout_hit) begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
        end
      end
    end
  end

  assign bus_req_valid = reset & (issue | (state == REQ));
  assign stallM        = reset & (issue | (state == REQ) | (state == WAIT));
  assign misalignM     = reset & in_idle & access & al_mis;
  assign buserrM       = reset & (state == DONE) & rsp_err;
  assign readdataM     = (state == DONE) ? rsp_data : '0;
  assign bus_we        = in_idle ? memwriteM : req_we;
  assign bus_addr      = {sel_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign bus_be        = al_be;
  assign bus_wdata     = al_wdata;
  assign lsu_state     = state;

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Directed scoreboard bench for lsu_bus_adapter (XLEN=32, TIMEOUT=4).
module tb_lsu_bus_adapter;
  import riscv_lsu_pkg::*;

  localparam int XLEN  = 32;
  localparam int REQ_W = 1 + 32 + 4 + 32;
  localparam int RSP_W = 1 + 32;
  localparam int MIS_W = 1 + 1 + 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              memreadM = 1'b0;
  logic              memwriteM = 1'b0;
  logic [2:0]        funct3M = 3'b0;
  logic [XLEN-1:0]   aluresultM = '0;
  logic [XLEN-1:0]   writedataM = '0;
  logic [XLEN-1:0]   readdataM;
  logic              stallM;
  logic              misalignM;
  logic              buserrM;
  logic              bus_req_valid;
  logic              bus_req_ready = 1'b0;
  logic              bus_we;
  logic [XLEN-1:0]   bus_addr;
  logic [XLEN-1:0]   bus_wdata;
  logic [XLEN/8-1:0] bus_be;
  logic              bus_rsp_valid = 1'b0;
  logic [XLEN-1:0]   bus_rdata = '0;
  logic [1:0]        lsu_state;

  logic [REQ_W-1:0] exp_req_q[$];
  logic [RSP_W-1:0] exp_rsp_q[$];
  logic [MIS_W-1:0] exp_mis_q[$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lsu_bus_adapter #(.XLEN(XLEN), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .memreadM(memreadM), .memwriteM(memwriteM),
    .funct3M(funct3M), .aluresultM(aluresultM), .writedataM(writedataM),
    .readdataM(readdataM), .stallM(stallM), .misalignM(misalignM), .buserrM(buserrM),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata), .lsu_state(lsu_state)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic unexpected(input string name);
    tests++;
    fails++;
    $display("FAIL %s: DUT output with no expected entry at %0t", name, $time);
  endtask

  // Monitor: compares every DUT presentation against the head of its queue.
  always @(negedge clk) begin
    if (reset) begin
      if (bus_req_valid) begin
        if (exp_req_q.size() == 0) unexpected("req_unexpected");
        else begin
          check("req_fields", 128'({bus_we, bus_addr, bus_be, bus_wdata}), 128'(exp_req_q[0]));
          if (bus_req_ready) void'(exp_req_q.pop_front());
        end
      end
      if (lsu_state == ST_DONE) begin
        if (exp_rsp_q.size() == 0) unexpected("rsp_unexpected");
        else check("rsp_err_data", 128'({buserrM, readdataM}), 128'(exp_rsp_q.pop_front()));
      end
      if (misalignM) begin
        if (exp_mis_q.size() == 0) unexpected("misalign_unexpected");
        else check("misalign_outputs", 128'({stallM, bus_req_valid, readdataM}),
                   128'(exp_mis_q.pop_front()));
      end
    end
  end

  // Aligned access; entered and left just after a rising edge.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int rdy_delay, input int rsp_delay, input logic [31:0] rdata,
                        input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wd, input logic [31:0] e_rd,
                        input logic e_err, input int e_stall);
    int stall_cnt = 0;
    int cyc = 0;
    int rc = rdy_delay;
    int k = 0;
    bit hs = 0;
    bit fin = 0;
    exp_req_q.push_back({wr, e_addr, e_be, e_wd});
    exp_rsp_q.push_back({e_err, e_rd});
    memreadM = rd; memwriteM = wr; funct3M = f3; aluresultM = addr; writedataM = wd;
    bus_req_ready = (rc == 0);
    while (!hs && cyc < 64) begin
      @(negedge clk);
      if (stallM) stall_cnt++;
      hs = bus_req_valid && bus_req_ready;
      @(posedge clk); #1;
      cyc++;
      if (!hs && rc > 0) rc--;
      bus_req_ready = !hs && (rc == 0);
    end
    while (hs && !fin && cyc < 64) begin
      bus_rsp_valid = (k == rsp_delay);
      bus_rdata = (k == rsp_delay) ? rdata : 32'hBAD0BAD0;
      @(negedge clk);
      if (stallM) stall_cnt++;
      @(posedge clk); #1;
      cyc++;
      k++;
      bus_rsp_valid = 1'b0;
      fin = (lsu_state == ST_DONE);
    end
    if (!fin) begin
      tests++;
      fails++;
      $display("FAIL access_complete: addr 0x%0h not done after %0d cycles", addr, cyc);
    end
    @(negedge clk);
    if (stallM) stall_cnt++;
    check("stall_cycles", 128'(stall_cnt), 128'(e_stall));
    @(posedge clk); #1;
    memreadM = 1'b0; memwriteM = 1'b0;
  endtask

  task automatic misaligned(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd);
    exp_mis_q.push_back('0);
    memreadM = rd; memwriteM = wr; funct3M = f3; aluresultM = addr; writedataM = wd;
    bus_req_ready = 1'b1;
    @(negedge clk);
    check("misalign_flag", 128'(misalignM), 128'(1));
    @(posedge clk); #1;
    memreadM = 1'b0; memwriteM = 1'b0; bus_req_ready = 1'b0;
    @(negedge clk);
    check("misalign_stays_idle", 128'(lsu_state), 128'(ST_IDLE));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a misaligned load pending: all flags must be held low.
    memreadM = 1'b1; funct3M = LW; aluresultM = 32'h101; bus_req_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 128'({stallM, bus_req_valid, misalignM, buserrM}), 128'(0));
    @(posedge clk); #1;
    reset = 1'b1; memreadM = 1'b0; aluresultM = '0; bus_req_ready = 1'b0;
    @(negedge clk);
    check("reset_state", 128'({lsu_state, readdataM}), 128'({ST_IDLE, 32'h0}));
    @(posedge clk); #1;

    //     rd wr f3   addr       wdata        rdy rsp rdata         e_addr      be     e_wdata       e_rd          err stall
    access(1, 0, LW,  32'h100, 32'h0,        0, 0,  32'hDEADBEEF, 32'h100, 4'hF, 32'h0,        32'hDEADBEEF, 0, 2);
    access(1, 0, LB,  32'h103, 32'h0,        0, 1,  32'h80000000, 32'h100, 4'h8, 32'h0,        32'hFFFFFF80, 0, 3);
    access(1, 0, LBU, 32'h103, 32'h0,        0, 0,  32'h80000000, 32'h100, 4'h8, 32'h0,        32'h00000080, 0, 2);
    access(0, 1, SH,  32'h202, 32'h1234,     3, 0,  32'hFFFFFFFF, 32'h200, 4'hC, 32'h12341234, 32'h0,        0, 5);
    access(1, 0, LH,  32'h102, 32'h0,        1, 0,  32'h80010000, 32'h100, 4'hC, 32'h0,        32'hFFFF8001, 0, 3);
    access(1, 0, LHU, 32'h102, 32'h0,        0, 0,  32'h80010000, 32'h100, 4'hC, 32'h0,        32'h00008001, 0, 2);
    access(1, 0, LH,  32'h100, 32'h0,        0, 0,  32'h12347FFF, 32'h100, 4'h3, 32'h0,        32'h00007FFF, 0, 2);
    access(0, 1, SB,  32'h101, 32'hA5,       0, 2,  32'h0,        32'h100, 4'h2, 32'hA5A5A5A5, 32'h0,        0, 4);
    access(1, 1, SW,  32'h010, 32'hCAFEF00D, 0, 0,  32'h12345678, 32'h010, 4'hF, 32'hCAFEF00D, 32'h0,        0, 2);
    access(1, 0, LD,  32'h004, 32'h0,        0, 0,  32'h80000001, 32'h004, 4'hF, 32'h0,        32'h80000001, 0, 2);
    access(1, 0, LWU, 32'h008, 32'h0,        0, 0,  32'h80000001, 32'h008, 4'hF, 32'h0,        32'h80000001, 0, 2);

    misaligned(1, 0, LW, 32'h101, 32'h0);
    misaligned(1, 0, LH, 32'h103, 32'h0);
    misaligned(0, 1, SW, 32'h102, 32'h55);
    misaligned(0, 1, SH, 32'h201, 32'h66);

    // No response at all: four WAIT cycles, then DONE with an error.
    access(1, 0, LW, 32'h040, 32'h0, 0, -1, 32'h0, 32'h040, 4'hF, 32'h0, 32'h0, 1, 5);

    // A response while idle is dropped.
    bus_rsp_valid = 1'b1; bus_rdata = 32'h55555555;
    @(negedge clk);
    check("stray_rsp_idle", 128'({lsu_state, stallM}), 128'({ST_IDLE, 1'b0}));
    @(posedge clk); #1;
    bus_rsp_valid = 1'b0;
    @(negedge clk);
    check("stray_rsp_no_done", 128'(lsu_state), 128'(ST_IDLE));
    @(posedge clk); #1;

    // Reset while waiting, then a late response that must be ignored.
    exp_req_q.push_back({1'b0, 32'h300, 4'hF, 32'h0});
    memreadM = 1'b1; funct3M = LW; aluresultM = 32'h300; writedataM = '0; bus_req_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus_req_ready = 1'b0;
    @(negedge clk);
    check("abandon_in_wait", 128'({lsu_state, stallM}), 128'({ST_WAIT, 1'b1}));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abandon_reset_outputs", 128'({stallM, bus_req_valid}), 128'(0));
    @(posedge clk); #1;
    reset = 1'b1; memreadM = 1'b0; bus_rsp_valid = 1'b1; bus_rdata = 32'h11111111;
    @(negedge clk);
    check("late_rsp_ignored", 128'({lsu_state, stallM, readdataM}), 128'({ST_IDLE, 1'b0, 32'h0}));
    @(posedge clk); #1;
    bus_rsp_valid = 1'b0;
    @(negedge clk);
    check("late_rsp_no_done", 128'(lsu_state), 128'(ST_IDLE));
    @(posedge clk); #1;
    access(1, 0, LW, 32'h304, 32'h0, 0, 0, 32'h0BADF00D, 32'h304, 4'hF, 32'h0, 32'h0BADF00D, 0, 2);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("req_queue_drained", 128'(exp_req_q.size()), 128'(0));
    check("rsp_queue_drained", 128'(exp_rsp_q.size()), 128'(0));
    check("mis_queue_drained", 128'(exp_mis_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
